// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Mode encoding and switch field positions live here.
package led_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLINK = 2'd2,
        CHASE = 2'd3
    } mode_t;

    localparam int MODE_LSB = 0;
    localparam int RATE_LSB = 2;
    localparam int DIV_BASE_DEF = 20000000;

    function automatic int cnt_width(int base);
        return $clog2(base * 8);
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Switch/LED bundle between the board pins and the sequencer.
// master drives switches and hold, slave drives the LEDs.
interface led_pattern_seq_if #(
    parameter int NUM_LED = 3
);
    logic [3:0]         s;
    logic               hold;
    logic [NUM_LED-1:0] led;
    logic               tick;

    modport master (
        output s,
        output hold,
        input  led,
        input  tick
    );

    modport slave (
        input  s,
        input  hold,
        output led,
        output tick
    );
endinterface

// File: rtl/led_tick_gen.sv
// Shared prescaler: period DIV_BASE << rate, step strobe at P-1.
// tick is a combinational strobe; the top registers it.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int DIV_BASE = DIV_BASE_DEF,
    parameter int CW       = cnt_width(DIV_BASE)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] rate,
    input  logic       clear,
    input  logic       hold,
    output logic       tick
);

    localparam logic [CW-1:0] BASE = CW'(DIV_BASE);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    logic          at_last;

    // x8 may wrap to 0 in CW bits; the -1 then lands on all-ones.
    assign last    = (BASE << rate) - CW'(1);
    assign at_last = (cnt == last);
    assign tick    = at_last & ~hold & ~clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            if (at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED bank sequencer: switch sync, change detect, pattern FSM.
// All LED drive comes straight from flops.
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int DIV_BASE    = DIV_BASE_DEF,
    parameter int NUM_LED     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    led_pattern_seq_if.slave  bus
);

    localparam int CW = cnt_width(DIV_BASE);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  sel_sync;
    logic [3:0]                  cur_sel;
    logic                        change;
    mode_t                       cur_mode;
    mode_t                       new_mode;
    logic [1:0]                  cur_rate;
    logic                        step;
    logic [NUM_LED-1:0]          led_q;
    logic                        tick_q;

    function automatic logic [NUM_LED-1:0] init_led(mode_t m);
        logic [NUM_LED-1:0] v;
        v = '0;
        unique case (m)
            OFF:   v = '0;
            ON:    v = '1;
            BLINK: v = '0;
            CHASE: v = NUM_LED'(1);
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.s};
        end
    end

    assign sel_sync = sync_q[SYNC_STAGES-1];
    assign change   = (sel_sync != cur_sel);
    assign cur_mode = mode_t'(cur_sel[MODE_LSB +: 2]);
    assign new_mode = mode_t'(sel_sync[MODE_LSB +: 2]);
    assign cur_rate = cur_sel[RATE_LSB +: 2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_sel <= '0;
        end else if (change) begin
            cur_sel <= sel_sync;
        end
    end

    led_tick_gen #(
        .DIV_BASE (DIV_BASE),
        .CW       (CW)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .rate    (cur_rate),
        .clear   (change),
        .hold    (bus.hold),
        .tick    (step)
    );

    // A selection change reinitialises the pattern even under hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= step;
            if (change) begin
                led_q <= init_led(new_mode);
            end else if (step) begin
                unique case (cur_mode)
                    OFF:   led_q <= '0;
                    ON:    led_q <= '1;
                    BLINK: led_q <= ~led_q;
                    CHASE: led_q <= {led_q[NUM_LED-2:0],
                                     led_q[NUM_LED-1]};
                endcase
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick_q;

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Sequences the board's LED bank from the user DIP switches.
- Switches choose a display mode (off / solid / blink / chase) and a rate.
- A shared prescaler produces the pattern step tick from the HSOSC clock.
- Sits between the raw switch pins and the LED pins, in place of per-LED ad-hoc counters.

Parameters:
- DIV_BASE, 20000000, clocks per step tick at rate 0 (about 0.42 s at 48 MHz); must be >= 2.
- NUM_LED, 3, number of LED outputs driven; must be >= 2.
- SYNC_STAGES, 2, flip-flop depth of the switch synchronizer; must be >= 2.

Ports:
- clk  in  1  HSOSC system clock.
- reset_n  in  1  Asynchronous active-low reset.
- s  in  4  Raw asynchronous switches: s[1:0] = mode, s[3:2] = rate.
- hold  in  1  Synchronous freeze of pattern and prescaler, active-high.
- led  out  NUM_LED  LED drive, active-high, registered.
- tick  out  1  One-cycle step pulse, registered; debug only.

Behaviour:
- Reset:
  - reset_n low clears all state immediately and asynchronously.
  - Outputs under reset: led = 0, tick = 0.
  - Internal state under reset: synchronizer = 0, mode = OFF, rate = 0, counter = 0, chase pointer = bit 0, blink phase = 0.
- Synchronizer:
  - s passes through SYNC_STAGES flops.
  - The final stage feeds a registered copy, cur_sel.
  - A change is detected when the synchronized value differs from cur_sel.
- Selection change (any bit):
  - On the detect cycle, cur_sel loads the new value, the counter clears to 0 and tick is suppressed.
  - Rate change resets the pattern phase.
  - Mode change re-enters the new mode at its initial pattern.
  - The new led value is visible SYNC_STAGES+1 clocks after s changes (3 with defaults).
- Prescaler:
  - Period P = DIV_BASE << rate, so rate 0..3 gives x1, x2, x4, x8.
  - Counter width is clog2(DIV_BASE*8).
  - The counter counts 0..P-1 and wraps to 0.
  - tick is high for the one cycle where the counter is at P-1 and not held.
  - The first tick after a reset or selection change occurs P clocks after the clear.
- hold:
  - While hold=1, the counter, pattern state and led are frozen, and tick = 0.
  - On release, counting resumes from the frozen value.
  - A selection change during hold is still applied: counter cleared, pattern reinitialised, led updated.
- Modes (mode_t):
  - OFF=0: led = all 0; ticks ignored.
  - ON=1: led = all 1; ticks ignored.
  - BLINK=2: entry gives led = all 0; each tick toggles all bits together.
  - CHASE=3: entry gives led = one-hot bit 0; each tick rotates left by 1, and bit NUM_LED-1 wraps to bit 0.
- Simultaneous events:
  - A selection change and the counter reaching P-1 in the same cycle: the change wins and no tick is issued.
  - reset_n asserted at any point, including mid-chase or mid-hold, forces the reset values on the next edge-independent evaluation.
- Glitch freedom: led is driven only from flops; no combinational path from s or hold to led.

Decomposition:
- Shared package led_pkg holds:
  - mode_t enum {OFF, ON, BLINK, CHASE} as 2-bit logic.
  - Constants MODE_LSB = 0, RATE_LSB = 2.
  - Default DIV_BASE constant.
- Sub-module led_tick_gen contains the prescaler:
  - Inputs: clk, reset_n, rate, clear, hold.
  - Output: tick.
- The top-level block owns the synchronizer, change detect and pattern FSM.

Test Plan:
- Common setup: DIV_BASE=4, NUM_LED=3, SYNC_STAGES=2, hold=0 unless stated.
1. Reset:
   - Stimulus: hold reset_n low 5 clocks with s=4'b0011, then release.
   - Response: led=000 and tick=0 during reset; CHASE led=001 appears exactly 3 clocks after release.
2. Mode ON:
   - Stimulus: from OFF, set s=4'b0001.
   - Response: led stays 000 for 2 clocks, then shows 111 on clock 3 and holds; tick pulses every 4 clocks with led unchanged.
3. BLINK rate 0:
   - Stimulus: s=4'b0010.
   - Response: led=000, then toggles 111/000 every 4 clocks; tick aligned with each toggle.
4. CHASE rate 1:
   - Stimulus: s=4'b0111.
   - Response: led sequence 001, 010, 100, 001, each held 8 clocks.
5. Rate change mid-count:
   - Stimulus: in CHASE rate 0 with counter=2, switch s[3:2] to 2'b10.
   - Response: pattern reinitialises to 001, no tick at the old boundary, next tick exactly 16 clocks after the detect cycle.
6. hold and async reset:
   - Stimulus: in CHASE at led=010, assert hold 20 clocks, release; then assert reset_n low mid-period.
   - Response: led=010 and tick=0 throughout hold, and advances to 100 after the remaining count; led=000 immediately on reset_n fall, without waiting for a clk edge.
